dram_arbiter: RTL

Two-port arbiter sharing the single DRAM controller between the 68030 CPU bus interface and a DMA/video master. Sits directly in front of the DRAM controller's request port. Latches one requester's command (address, byte enables, direction) and holds it stable for the whole DRAM cycle. Returns completion to the winner. Uses CPU-priority arbitration with DMA aging, plus a watchdog that converts a lost controller acknowledge into a bus error.

---
 rtl/dram_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/dram_arbiter.sv
// Two-port DRAM request arbiter: CPU priority with DMA aging,
// latched command fields and a lost-ack watchdog.
module dram_arbiter #(
  parameter int ADDR_W       = 28,
  parameter int DMA_MAX_WAIT = 16,
  parameter int TIMEOUT      = 255
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [3:0]        CPU_BE,
  output logic              CPU_ACK,
  output logic              CPU_ERR,
  input  logic              DMA_REQ,
  input  logic              DMA_WE,
  input  logic [ADDR_W-1:0] DMA_ADDR,
  input  logic [3:0]        DMA_BE,
  output logic              DMA_ACK,
  output logic              DMA_ERR,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [3:0]        MEM_BE,
  input  logic              MEM_ACK,
  output logic [1:0]        OWNER
);

  localparam int DW  = $clog2(DMA_MAX_WAIT + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int WW  = (TW > 8) ? TW : 8;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_DMA  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TURN = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [DW-1:0] dma_wait;
  logic [WW-1:0] wdog;
  logic          grant_cpu;
  logic          grant_dma;
  logic          timeout;
  logic          cpu_ack_nx;
  logic          cpu_err_nx;
  logic          dma_ack_nx;
  logic          dma_err_nx;

  // DMA wins a contested slot only once its aging counter saturates
  always_comb begin
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    if (state == IDLE) begin
      if (DMA_REQ && (!CPU_REQ ||
          dma_wait == DW'(DMA_MAX_WAIT)))
        grant_dma = 1'b1;
      else if (CPU_REQ)
        grant_cpu = 1'b1;
    end
  end

  assign timeout = (state == BUSY) && !MEM_ACK &&
                   (wdog == WW'(TIMEOUT - 1));

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (grant_cpu || grant_dma) state_nx = BUSY;
      BUSY:
        if (MEM_ACK || timeout) state_nx = TURN;
      TURN:
        state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_comb begin
    cpu_ack_nx = 1'b0;
    cpu_err_nx = 1'b0;
    dma_ack_nx = 1'b0;
    dma_err_nx = 1'b0;
    if (state == BUSY) begin
      cpu_ack_nx = MEM_ACK && (OWNER == OWN_CPU);
      dma_ack_nx = MEM_ACK && (OWNER == OWN_DMA);
      cpu_err_nx = timeout && (OWNER == OWN_CPU);
      dma_err_nx = timeout && (OWNER == OWN_DMA);
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      CPU_ACK  <= 1'b0;
      CPU_ERR  <= 1'b0;
      DMA_ACK  <= 1'b0;
      DMA_ERR  <= 1'b0;
      MEM_REQ  <= 1'b0;
      MEM_WE   <= 1'b0;
      MEM_ADDR <= '0;
      MEM_BE   <= '0;
      OWNER    <= OWN_NONE;
      wdog     <= '0;
    end else begin
      CPU_ACK <= cpu_ack_nx;
      CPU_ERR <= cpu_err_nx;
      DMA_ACK <= dma_ack_nx;
      DMA_ERR <= dma_err_nx;
      if (grant_cpu || grant_dma) begin
        MEM_REQ  <= 1'b1;
        MEM_WE   <= grant_dma ? DMA_WE   : CPU_WE;
        MEM_ADDR <= grant_dma ? DMA_ADDR : CPU_ADDR;
        MEM_BE   <= grant_dma ? DMA_BE   : CPU_BE;
        OWNER    <= grant_dma ? OWN_DMA  : OWN_CPU;
        wdog     <= '0;
      end else if (state == BUSY) begin
        if (MEM_ACK || timeout) begin
          MEM_REQ <= 1'b0;
          OWNER   <= OWN_NONE;
        end else begin
          wdog <= wdog + 1'b1;
        end
      end
    end
  end

  // Aging counts arbitrations the DMA lost to the CPU
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n)
      dma_wait <= '0;
    else if (!DMA_REQ || grant_dma)
      dma_wait <= '0;
    else if (grant_cpu && dma_wait != DW'(DMA_MAX_WAIT))
      dma_wait <= dma_wait + 1'b1;
  end

endmodule
